// File: rtl/vx_mem_sched.sv
// vx_mem_sched: round-robin scheduler of NUM_REQS line requesters onto one memory port, with read-credit tracking and response routing.
// Latency: requester accept -> mem_req_valid is 1 cycle (registered output stage); responses are routed combinationally (0 cycles).
// Backpressure: the stage holds while mem_req_ready=0; reads stall once MAX_PENDING are in flight; mem_rsp_ready mirrors the addressed requester's rsp_ready.
//
// Ports:
//   clk, reset (async, active-low)
//   req_*       per-requester request channel (flattened payload), req_ready = one-hot grant
//   mem_req_*   registered memory request, tag = {req_tag, requester index}
//   mem_rsp_*   memory response, routed to requester by tag LSBs
//   rsp_*       per-requester response valid/ready, shared data/tag
//   pending_reads, busy  status
module vx_mem_sched #(
    parameter int NUM_REQS    = 4,
    parameter int ADDR_WIDTH  = 26,
    parameter int DATA_WIDTH  = 512,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 16,
    localparam int IDX_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int BE_W   = DATA_WIDTH / 8,
    localparam int MTAG_W = TAG_WIDTH + IDX_W,
    localparam int CNT_W  = $clog2(MAX_PENDING) + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            req_valid,
    input  logic [NUM_REQS-1:0]            req_rw,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQS*BE_W-1:0]       req_byteen,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag,
    output logic [NUM_REQS-1:0]            req_ready,
    output logic                           mem_req_valid,
    output logic                           mem_req_rw,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr,
    output logic [DATA_WIDTH-1:0]          mem_req_data,
    output logic [BE_W-1:0]                mem_req_byteen,
    output logic [MTAG_W-1:0]              mem_req_tag,
    input  logic                           mem_req_ready,
    input  logic                           mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]          mem_rsp_data,
    input  logic [MTAG_W-1:0]              mem_rsp_tag,
    output logic                           mem_rsp_ready,
    output logic [NUM_REQS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [TAG_WIDTH-1:0]           rsp_tag,
    input  logic [NUM_REQS-1:0]            rsp_ready,
    output logic [CNT_W-1:0]               pending_reads,
    output logic                           busy
);

    logic                  out_vld;
    logic                  out_rw;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic [BE_W-1:0]       out_byteen;
    logic [MTAG_W-1:0]     out_tag;

    logic [IDX_W-1:0]      rr_ptr;
    logic [NUM_REQS-1:0]   eligible;
    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic                  can_load;
    logic                  grant;
    logic                  stage_rd;
    logic [CNT_W:0]        credit_sum;
    logic                  reads_ok;
    logic                  rd_fire;
    logic                  rsp_fire;
    logic                  rsp_dec;
    logic [IDX_W-1:0]      rsp_idx;

    assign can_load = !out_vld || mem_req_ready;
    assign rd_fire  = out_vld && mem_req_ready && !out_rw;

    // A read sitting in the output stage already holds a credit, so it is
    // counted alongside the in-flight reads when deciding read eligibility.
    assign stage_rd   = out_vld && !out_rw;
    assign credit_sum = {1'b0, pending_reads} + {{CNT_W{1'b0}}, stage_rd};
    assign reads_ok   = credit_sum < (CNT_W+1)'(MAX_PENDING);
    assign eligible   = req_valid & (req_rw | {NUM_REQS{reads_ok}});

    // Scan from the priority pointer, wrapping; first eligible requester wins.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQS) j = j - NUM_REQS;
            if (!win_found && eligible[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    // Gating with reset keeps req_ready low throughout reset even though the
    // empty stage would otherwise look loadable.
    assign grant = win_found && can_load && reset;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[win_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_vld <= 1'b0;
            rr_ptr  <= '0;
        end else begin
            if (can_load) out_vld <= grant;
            if (grant)
                rr_ptr <= (int'(win_idx) == NUM_REQS - 1) ? '0 : win_idx + 1'b1;
        end
    end

    // Payload needs no reset: it is only observed while out_vld is set.
    always_ff @(posedge clk) begin
        if (grant) begin
            out_rw     <= req_rw[win_idx];
            out_addr   <= req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            out_data   <= req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            out_byteen <= req_byteen[int'(win_idx)*BE_W +: BE_W];
            out_tag    <= {req_tag[int'(win_idx)*TAG_WIDTH +: TAG_WIDTH], win_idx};
        end
    end

    assign mem_req_valid  = out_vld;
    assign mem_req_rw     = out_rw;
    assign mem_req_addr   = out_addr;
    assign mem_req_data   = out_data;
    assign mem_req_byteen = out_byteen;
    assign mem_req_tag    = out_tag;

    // Response routing: a single requester has no index bits to decode.
    assign rsp_idx  = (NUM_REQS == 1) ? '0 : mem_rsp_tag[IDX_W-1:0];
    assign rsp_tag  = mem_rsp_tag[IDX_W +: TAG_WIDTH];
    assign rsp_data = mem_rsp_data;

    always_comb begin
        rsp_valid     = '0;
        mem_rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (int'(rsp_idx) == i) begin
                rsp_valid[i]  = mem_rsp_valid;
                mem_rsp_ready = rsp_ready[i];
            end
        end
    end

    assign rsp_fire = mem_rsp_valid && mem_rsp_ready;
    // A response with nothing outstanding is ignored so the count cannot wrap.
    assign rsp_dec  = rsp_fire && (pending_reads != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_reads <= '0;
        end else if (rd_fire && !rsp_dec) begin
            if (pending_reads != CNT_W'(MAX_PENDING))
                pending_reads <= pending_reads + 1'b1;
        end else if (!rd_fire && rsp_dec) begin
            pending_reads <= pending_reads - 1'b1;
        end
    end

    assign busy = out_vld || (pending_reads != '0);

    a_no_unexpected_rsp: assert property (@(posedge clk) disable iff (!reset)
        !(rsp_fire && pending_reads == '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(rd_fire && !rsp_dec && pending_reads == CNT_W'(MAX_PENDING)));

endmodule

// File: tb/tb_vx_mem_sched.sv
// tb_vx_mem_sched: randomized and directed stimulus for vx_mem_sched against a transaction-level model.
// Latency: model expects requests at the memory port one cycle after accept, responses routed in the same cycle.
// Backpressure: bench randomizes mem_req_ready and rsp_ready and tracks read credits as a list of outstanding tags.
module tb_vx_mem_sched;

    localparam int N  = 4;
    localparam int AW = 26;
    localparam int DW = 64;
    localparam int TW = 8;
    localparam int MP = 16;
    localparam int IW = 2;
    localparam int BW = DW / 8;
    localparam int CW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_rw, req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N*BW-1:0]   req_byteen;
    logic [N*TW-1:0]   req_tag;
    logic              mem_req_valid, mem_req_rw, mem_req_ready;
    logic [AW-1:0]     mem_req_addr;
    logic [DW-1:0]     mem_req_data;
    logic [BW-1:0]     mem_req_byteen;
    logic [TW+IW-1:0]  mem_req_tag;
    logic              mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0]     mem_rsp_data;
    logic [TW+IW-1:0]  mem_rsp_tag;
    logic [N-1:0]      rsp_valid, rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic [TW-1:0]     rsp_tag;
    logic [CW-1:0]     pending_reads;
    logic              busy;

    always #5 clk = ~clk;

    vx_mem_sched #(
        .NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .req_byteen(req_byteen), .req_tag(req_tag), .req_ready(req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_ready(mem_rsp_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
        .pending_reads(pending_reads), .busy(busy)
    );

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
        logic [TW+IW-1:0] tag;   // full memory-side tag {req_tag, index}
    } txn_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what sits in the output stage, which reads are in flight,
    // who was granted last, and each requester's held transaction.
    txn_t             st_q[$];
    logic [TW+IW-1:0] out_rd[$];
    int               last_win;
    logic             rv[N];
    txn_t             rq[N];

    // Stimulus knobs.
    int               gen_mode;   // 0 none, 1 random, 2 refill reads on all, 3 refill reads on req 0
    logic             mrdy;
    int               rsp_mode;   // 0 none, 1 random, 2 one-shot at rsp_sel, 3 always oldest
    int               rsp_sel;
    logic [N-1:0]     rrdy_v;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic txn_t new_txn(input int i, input logic rw);
        txn_t t;
        t.rw   = rw;
        t.addr = AW'($urandom);
        t.data = {$urandom, $urandom};
        t.be   = BW'($urandom);
        t.tag  = {TW'($urandom), IW'(i)};
        return t;
    endfunction

    function automatic bit any_rv();
        bit a;
        a = 0;
        for (int i = 0; i < N; i++) if (rv[i]) a = 1;
        return a;
    endfunction

    // One clock: drive at negedge, check at negedge+1, then advance the model
    // to what the next rising edge must produce.
    task automatic step();
        bit               rsp_en;
        int               sel, win, bestd, d, stage_rd, ridx;
        logic [N-1:0]     exp_rdy;
        bit               can_load;
        logic [TW+IW-1:0] dtag;
        logic [DW-1:0]    rdat;

        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!rv[i]) begin
                case (gen_mode)
                    1: if ($urandom_range(0, 2) == 0) begin
                           rq[i] = new_txn(i, 1'($urandom_range(0, 1))); rv[i] = 1;
                       end
                    2: begin rq[i] = new_txn(i, 1'b0); rv[i] = 1; end
                    3: if (i == 0) begin rq[i] = new_txn(i, 1'b0); rv[i] = 1; end
                    default: ;
                endcase
            end
        end
        if (gen_mode == 1) mrdy = ($urandom_range(0, 3) != 0);

        rsp_en = 0;
        sel    = 0;
        if (out_rd.size() > 0) begin
            if (rsp_mode == 1 && $urandom_range(0, 1) == 1) begin
                rsp_en = 1; sel = $urandom_range(0, out_rd.size() - 1);
            end else if (rsp_mode == 2) begin
                rsp_en = 1; sel = rsp_sel;
            end else if (rsp_mode == 3) begin
                rsp_en = 1; sel = 0;
            end
        end
        if (rsp_mode == 2) rsp_mode = 0;
        if (rsp_mode == 1) rrdy_v = N'($urandom | $urandom);

        dtag = rsp_en ? out_rd[sel] : (TW+IW)'($urandom);
        rdat = {$urandom, $urandom};
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = rv[i];
            req_rw[i]              = rq[i].rw;
            req_addr[i*AW +: AW]   = rq[i].addr;
            req_data[i*DW +: DW]   = rq[i].data;
            req_byteen[i*BW +: BW] = rq[i].be;
            req_tag[i*TW +: TW]    = rq[i].tag[IW +: TW];
        end
        mem_req_ready = mrdy;
        mem_rsp_valid = rsp_en;
        mem_rsp_tag   = dtag;
        mem_rsp_data  = rdat;
        rsp_ready     = rrdy_v;
        #1;

        check("mreq_vld", mem_req_valid, st_q.size() > 0);
        if (st_q.size() > 0) begin
            check("mreq_rw",   mem_req_rw,     st_q[0].rw);
            check("mreq_addr", mem_req_addr,   st_q[0].addr);
            check("mreq_data", mem_req_data,   st_q[0].data);
            check("mreq_be",   mem_req_byteen, st_q[0].be);
            check("mreq_tag",  mem_req_tag,    st_q[0].tag);
        end
        check("pending", pending_reads, out_rd.size());
        check("busy", busy, (st_q.size() > 0) || (out_rd.size() > 0));

        // Expected grant: eligible requester nearest after the last winner.
        can_load = (st_q.size() == 0) || mrdy;
        stage_rd = (st_q.size() > 0 && !st_q[0].rw) ? 1 : 0;
        win      = -1;
        bestd    = N;
        for (int i = 0; i < N; i++) begin
            if (rv[i] && (rq[i].rw || (out_rd.size() + stage_rd < MP))) begin
                d = (i - last_win - 1 + 2 * N) % N;
                if (d < bestd) begin bestd = d; win = i; end
            end
        end
        exp_rdy = '0;
        if (win >= 0 && can_load) exp_rdy[win] = 1'b1;
        check("req_ready", req_ready, exp_rdy);

        check("rsp_valid", rsp_valid, rsp_en ? (N'(1) << dtag[IW-1:0]) : '0);
        check("rsp_tag", rsp_tag, dtag[IW +: TW]);
        check("rsp_data", rsp_data, rdat);
        check("mrsp_ready", mem_rsp_ready, rrdy_v[dtag[IW-1:0]]);

        if (rsp_en) begin
            ridx = int'(out_rd[sel][IW-1:0]);
            if (rrdy_v[ridx]) out_rd.delete(sel);
        end
        if (st_q.size() > 0 && mrdy) begin
            if (!st_q[0].rw) out_rd.push_back(st_q[0].tag);
            void'(st_q.pop_front());
        end
        if (win >= 0 && can_load) begin
            st_q.push_back(rq[win]);
            rv[win]  = 0;
            last_win = win;
        end
    endtask

    task automatic drain();
        gen_mode = 0; mrdy = 1; rsp_mode = 3; rrdy_v = '1;
        for (int c = 0; c < 200; c++) begin
            if (st_q.size() == 0 && out_rd.size() == 0 && !any_rv()) break;
            step();
        end
        rsp_mode = 0;
        step();
        check("drain_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int   seq[5];
        logic [AW-1:0]    h_addr;
        logic [DW-1:0]    h_data;
        logic [TW+IW-1:0] h_tag;
        seq = '{0, 1, 2, 3, 0};

        reset = 1'b0;
        req_valid = '0; req_rw = '0; req_addr = '0; req_data = '0; req_byteen = '0; req_tag = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0; mem_rsp_tag = '0; rsp_ready = '0;
        gen_mode = 0; mrdy = 0; rsp_mode = 0; rsp_sel = 0; rrdy_v = '1; last_win = N - 1;
        for (int i = 0; i < N; i++) begin rv[i] = 0; rq[i] = new_txn(i, 1'b0); end

        // Reset state, with all requesters asking.
        #2 req_valid = '1;
        #1;
        check("rst_mreq_vld", mem_req_valid, 0);
        check("rst_req_rdy", req_ready, 0);
        check("rst_pending", pending_reads, 0);
        check("rst_busy", busy, 0);
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Round-robin order with four persistent readers.
        gen_mode = 2; mrdy = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k >= 1) check("rr_tag_idx", mem_req_tag[IW-1:0], seq[k-1]);
            if (k < 5)  check("rr_grant", req_ready, N'(1) << seq[k]);
        end
        drain();

        // Stall with a request loaded: stage stable, no grants, pointer held.
        rq[1] = new_txn(1, 1'b0); rv[1] = 1; mrdy = 0;
        step();
        check("hold_first", req_ready, 4'b0010);
        rq[0] = new_txn(0, 1'b0); rv[0] = 1;
        rq[2] = new_txn(2, 1'b1); rv[2] = 1;
        step();
        h_addr = mem_req_addr; h_data = mem_req_data; h_tag = mem_req_tag;
        for (int k = 0; k < 4; k++) begin
            step();
            check("hold_vld", mem_req_valid, 1);
            check("hold_addr", mem_req_addr, h_addr);
            check("hold_data", mem_req_data, h_data);
            check("hold_tag", mem_req_tag, h_tag);
            check("hold_rdy", req_ready, 0);
        end
        mrdy = 1;
        step();
        check("hold_ptr", req_ready, 4'b0100);
        drain();

        // Credit limit: sixteen reads outstanding block reads but not writes.
        gen_mode = 2; mrdy = 1;
        for (int c = 0; c < 60; c++) begin
            if (out_rd.size() == MP) break;
            step();
        end
        gen_mode = 0;
        step();
        check("full_cnt", pending_reads, 16);
        check("full_block", req_ready, 0);
        rq[1] = new_txn(1, 1'b1); rv[1] = 1;
        step();
        check("full_wr", req_ready, 4'b0010);
        rsp_mode = 2; rsp_sel = 0; rrdy_v = '1;
        step();
        step();
        check("one_rsp_cnt", pending_reads, 15);
        check("one_rsp_grant", req_ready != 0, 1);
        drain();

        // Response routing and backpressure from the addressed requester.
        rq[2] = new_txn(2, 1'b0); rq[2].tag = {8'hA5, 2'd2}; rv[2] = 1;
        step();
        step();
        rsp_mode = 2; rsp_sel = 0; rrdy_v = 4'b1011;
        step();
        check("rsp_route", rsp_valid, 4'b0100);
        check("rsp_tag_a5", rsp_tag, 8'hA5);
        check("rsp_bp", mem_rsp_ready, 0);
        rsp_mode = 2; rsp_sel = 0; rrdy_v = '1;
        step();
        check("rsp_acc", mem_rsp_ready, 1);
        drain();

        // Read fire and response in the same cycle at count 7.
        gen_mode = 3; mrdy = 1;
        for (int c = 0; c < 50; c++) begin
            if (out_rd.size() == 7 && st_q.size() == 1 && !st_q[0].rw) break;
            step();
        end
        gen_mode = 0; rsp_mode = 2; rsp_sel = 0; rrdy_v = '1;
        step();
        check("cnt7_pre", pending_reads, 7);
        step();
        check("cnt7_same", pending_reads, 7);
        drain();

        // Random traffic, then asynchronous reset between edges.
        gen_mode = 1; rsp_mode = 1;
        repeat (30) step();
        for (int c = 0; c < 50; c++) begin
            if (st_q.size() > 0) break;
            step();
        end
        @(posedge clk);
        #3;
        check("arst_pre_vld", mem_req_valid, st_q.size() > 0);
        check("arst_pre_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("arst_mreq", mem_req_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_rdy", req_ready, 0);
        check("arst_cnt", pending_reads, 0);
        req_valid = '0; mem_rsp_valid = 0;
        st_q.delete(); out_rd.delete(); last_win = N - 1;
        for (int i = 0; i < N; i++) rv[i] = 0;
        gen_mode = 0; rsp_mode = 0; mrdy = 1; rrdy_v = '1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rq[1] = new_txn(1, 1'b0); rv[1] = 1;
        rq[3] = new_txn(3, 1'b0); rv[3] = 1;
        step();
        check("post_rst_cnt", pending_reads, 0);
        check("post_rst_ptr", req_ready, 4'b0010);
        drain();

        // Long randomized run.
        gen_mode = 1; rsp_mode = 1;
        repeat (1500) step();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_mem_sched.md
VX_MEM_SCHED -- requirements
Module: VX_mem_sched

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of requesters sharing the memory port (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 26: line address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 512: line data width; byteen width = DATA_WIDTH/8.
REQ-004 SHALL have parameter TAG_WIDTH, default 8: requester tag width.
REQ-005 SHALL have parameter MAX_PENDING, default 16: maximum outstanding reads (power of 2).
REQ-006 SHALL have: clk  in  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have: reset  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-008 SHALL have: req_valid / req_rw  in  NUM_REQS each  per-requester valid and write flag.
REQ-009 SHALL have: req_addr / req_data / req_byteen / req_tag  in  NUM_REQS x field width, flattened  per-requester payload.
REQ-010 SHALL have: req_ready  out  NUM_REQS  per-requester accept.
REQ-011 SHALL have: mem_req_valid, mem_req_rw  out  1 each; mem_req_addr/data/byteen  out  field widths; mem_req_tag  out  TAG_WIDTH+log2(NUM_REQS) (min 1 extra bit); mem_req_ready  in  1.
REQ-012 SHALL have: mem_rsp_valid  in  1; mem_rsp_data  in  DATA_WIDTH; mem_rsp_tag  in  TAG_WIDTH+log2(NUM_REQS); mem_rsp_ready  out  1.
REQ-013 SHALL have: rsp_valid  out  NUM_REQS; rsp_data  out  DATA_WIDTH (shared); rsp_tag  out  TAG_WIDTH (shared); rsp_ready  in  NUM_REQS.
REQ-014 SHALL have: pending_reads  out  log2(MAX_PENDING)+1  outstanding read count; busy  out  1.

Function
REQ-015 SHALL register the memory request: one output stage; mem_req_* driven only from that register; latency requester-accept to mem_req_valid = 1 cycle.
REQ-016 SHALL load the output stage when it is empty or firing this cycle (mem_req_valid && mem_req_ready); otherwise hold contents stable.
REQ-017 SHALL arbitrate round-robin among eligible requesters; priority pointer moves to (winner+1) mod NUM_REQS only on a grant.
REQ-018 SHALL treat a requester as eligible when req_valid=1 and (req_rw=1 or pending_reads + reads-in-output-stage < MAX_PENDING).
REQ-019 SHALL assert req_ready for at most one requester per cycle, the winner, and only when the output stage can load.
REQ-020 SHALL form mem_req_tag = {req_tag, winner index}, index in LSBs.
REQ-021 SHALL increment pending_reads on a read fire at the memory port, decrement on mem_rsp_valid && mem_rsp_ready; both same cycle -> unchanged.
REQ-022 SHALL route a response to requester i = mem_rsp_tag LSB index; rsp_valid[i]=mem_rsp_valid, rsp_tag=upper TAG_WIDTH bits, rsp_data=mem_rsp_data, mem_rsp_ready=rsp_ready[i]; combinational, zero latency.
REQ-023 SHALL never let pending_reads exceed MAX_PENDING nor underflow; an unexpected response at count 0 SHALL leave count at 0 (simulation assertion fires).
REQ-024 SHALL treat writes as posted: no response expected, no credit consumed.
REQ-025 SHALL assert busy when output stage valid or pending_reads != 0.
REQ-026 SHALL with NUM_REQS=1 bypass arbitration; tag index bit constant 0.

Reset
REQ-027 SHALL on reset=0, immediately and asynchronously: mem_req_valid=0, req_ready=0, pending_reads=0, busy=0, priority pointer=0, output-stage payload don't-care.
REQ-028 SHALL discard any in-flight request/credit state on reset mid-operation; responses arriving after release to a zero count follow REQ-023.
REQ-029 SHALL begin arbitration on the first rising clk edge after reset returns to 1.

Verification
REQ-030 SHALL verify: all 4 requesters hold valid reads, mem_req_ready=1 -> grants in order 0,1,2,3,0; mem_req_tag LSBs 0,1,2,3.
REQ-031 SHALL verify: mem_req_ready=0 for 5 cycles with request loaded -> mem_req_* stable, req_ready=0 all requesters, no pointer advance.
REQ-032 SHALL verify: 16 reads issued, no responses -> pending_reads=16, reads blocked, writes still granted; one response -> 15, next read granted.
REQ-033 SHALL verify: response with tag {8'hA5, 2'd2} -> rsp_valid=4'b0100, rsp_tag=8'hA5; rsp_ready[2]=0 -> mem_rsp_ready=0.
REQ-034 SHALL verify: read fire and response same cycle at count 7 -> count remains 7.
REQ-035 SHALL verify: reset driven 0 asynchronously mid-burst (between edges) -> mem_req_valid and busy fall to 0 before next edge; count=0 after release.
